// File: rtl/csa_pkg.sv
// ============================================================================
//  csa_pkg : state encoding and width helpers for the carry-save accumulator
//  Rev 1.0
// ============================================================================
`default_nettype none

package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

    // Result width large enough that max_ops full-scale operands never overflow
    function automatic int calc_acc_w(input int w, input int max_ops);
        return w + $clog2(max_ops);
    endfunction

    function automatic int calc_cnt_w(input int max_ops);
        return $clog2(max_ops) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_3to2.sv
// ============================================================================
//  csa_3to2 : combinational 3:2 carry-save compressor (s = x^y^z, c = maj<<1)
//  Rev 1.0
// ============================================================================
`default_nettype none

module csa_3to2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    assign s = x ^ y ^ z;

    // The majority of the top bit would shift out, so it is never formed
    assign c = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
                (x[WIDTH-2:0] & z[WIDTH-2:0]) |
                (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};

endmodule

`default_nettype wire

// File: rtl/csa_accum_ctrl.sv
// ============================================================================
//  csa_accum_ctrl : streams operands through a carry-save stage, then does one
//                   carry-propagate add and presents the sum on valid/ready.
//  Rev 1.0
// ============================================================================
`default_nettype none

module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int W       = 4,
    parameter int MAX_OPS = 8,
    parameter int CNT_W   = calc_cnt_w(MAX_OPS),
    parameter int ACC_W   = calc_acc_w(W, MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             err
);

    state_e             state_q;
    logic [ACC_W-1:0]   s_q;
    logic [ACC_W-1:0]   c_q;
    logic [CNT_W-1:0]   rem_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               err_q;

    logic [ACC_W-1:0]   operand_ext;
    logic [ACC_W-1:0]   sum_d;
    logic [ACC_W-1:0]   carry_d;
    logic               illegal_count;

    assign operand_ext   = {{(ACC_W-W){1'b0}}, in_data};
    assign illegal_count = (op_count == '0) || (op_count > CNT_W'(MAX_OPS));

    csa_3to2 #(
        .WIDTH (ACC_W)
    ) u_csa (
        .x (s_q),
        .y (c_q),
        .z (operand_ext),
        .s (sum_d),
        .c (carry_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            rem_q       <= '0;
            out_sum_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (illegal_count) begin
                            err_q <= 1'b1;
                        end else begin
                            s_q        <= '0;
                            c_q        <= '0;
                            rem_q      <= op_count;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        s_q   <= sum_d;
                        c_q   <= carry_d;
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    // Carry-out is dropped: the true sum always fits in ACC_W
                    out_sum_q   <= s_q + c_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_accum_ctrl.sv
// ============================================================================
//  tb_csa_accum_ctrl : scoreboard bench for the carry-save accumulator
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_csa_accum_ctrl;

    localparam int W       = 4;
    localparam int MAX_OPS = 8;
    localparam int CNT_W   = $clog2(MAX_OPS) + 1;
    localparam int ACC_W   = W + $clog2(MAX_OPS);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             busy;
    logic             err;

    int               n_vec;
    int               n_bad;
    logic [ACC_W-1:0] exp_q[$];
    logic [W-1:0]     ops [MAX_OPS];

    csa_accum_ctrl #(
        .W       (W),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_count  (op_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        ops[0] = a;
        ops[1] = b;
        ops[2] = c;
    endtask

    // Drive one full accumulation; gap inserts an idle in_valid cycle between
    // operands, hold_out stalls the consumer for 3 cycles while poking start.
    task automatic run_accum(input int n, input bit gap, input bit hold_out);
        logic [ACC_W-1:0] exp_sum;
        logic [ACC_W-1:0] exp_pop;
        int               budget;
        exp_sum = '0;
        for (int i = 0; i < n; i++) exp_sum = exp_sum + ACC_W'(ops[i]);
        exp_q.push_back(exp_sum);

        out_ready = hold_out ? 1'b0 : 1'b1;
        start     = 1'b1;
        op_count  = CNT_W'(n);
        tick();
        start     = 1'b0;
        op_count  = '0;
        check("busy_rise", busy, 1);
        check("in_ready_rise", in_ready, 1);

        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                in_data  = 4'hF;
                tick();
                check("stall_in_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
            in_valid = 1'b0;
        end
        check("resolve_out_valid", out_valid, 0);
        check("resolve_in_ready", in_ready, 0);

        tick();
        check("latency_out_valid", out_valid, 1);
        budget = 0;
        while (!out_valid && budget < 10) begin
            tick();
            budget++;
        end
        exp_pop = exp_q.pop_front();
        check("out_sum", out_sum, exp_pop);

        if (hold_out) begin
            for (int k = 0; k < 3; k++) begin
                start    = ~start;
                op_count = CNT_W'(2);
                tick();
                check("hold_out_valid", out_valid, 1);
                check("hold_out_sum", out_sum, exp_pop);
                check("hold_err", err, 0);
                check("hold_busy", busy, 1);
            end
            start     = 1'b0;
            out_ready = 1'b1;
        end

        tick();
        check("post_hs_busy", busy, 0);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_out_sum", out_sum, exp_pop);
    endtask

    task automatic illegal_start(input int cnt);
        start    = 1'b1;
        op_count = CNT_W'(cnt);
        tick();
        start    = 1'b0;
        op_count = '0;
        check("illegal_err_pulse", err, 1);
        check("illegal_busy", busy, 0);
        check("illegal_in_ready", in_ready, 0);
        tick();
        check("illegal_err_clear", err, 0);
        check("illegal_busy_after", busy, 0);
        check("illegal_in_ready_after", in_ready, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op_count  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_sum", out_sum, 0);
        rst_n = 1'b1;
        tick();

        load3(4'd13, 4'd9, 4'd4);
        run_accum(3, 1'b0, 1'b0);

        load3(4'd15, 4'd11, 4'd6);
        run_accum(3, 1'b1, 1'b0);

        for (int i = 0; i < MAX_OPS; i++) ops[i] = 4'd15;
        run_accum(MAX_OPS, 1'b0, 1'b0);

        ops[0] = 4'd7;
        run_accum(1, 1'b0, 1'b0);

        illegal_start(0);
        illegal_start(MAX_OPS + 1);

        load3(4'd13, 4'd9, 4'd4);
        run_accum(3, 1'b0, 1'b1);

        // Abandon a 4-operand run after two accepts
        start    = 1'b1;
        op_count = CNT_W'(4);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd5;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        check("midrst_out_sum", out_sum, 0);
        tick();

        ops[0] = 4'd13;
        ops[1] = 4'd13;
        run_accum(2, 1'b0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csa_accum_ctrl.md
# csa_accum_ctrl

Sequencing controller that accumulates a programmable-length stream of W-bit operands through a 3:2 carry-save compressor. It keeps the running total in redundant sum/carry form with no carry propagation per operand. After the last operand it performs one carry-propagate add and presents the result on a valid/ready output. It sits between an operand producer and any consumer of multi-operand sums, and reuses the team's carry-save stage as its datapath.

## Interface
Parameters:
- W, 4: operand width.
- MAX_OPS, 8: maximum operands per accumulation.
- CNT_W, $clog2(MAX_OPS)+1: width of op_count.
- ACC_W, W+$clog2(MAX_OPS): result width; guarantees no overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin accumulation; sampled only in IDLE.
- op_count  in  CNT_W  operand count, captured with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- in_data  in  W  operand, zero-extended to ACC_W.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  ACC_W  final sum.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse: start with op_count==0 or op_count>MAX_OPS.

## Operation
States are IDLE, ACCUM, RESOLVE and OUTPUT.
- **IDLE:** on start with a legal op_count, clear S and C (ACC_W each), load remaining=op_count and go to ACCUM. On an illegal op_count, pulse err and stay in IDLE.
- **ACCUM:** in_ready=1. On each accept:
  - S <= S ^ C ^ x.
  - C <= (maj(S,C,x) << 1) truncated to ACC_W.
  - remaining decrements.
  - An accept with remaining==1 moves to RESOLVE.
- **RESOLVE:** register out_sum <= S + C (ACC_W bits, carry-out discarded), then go to OUTPUT.
- **OUTPUT:** out_valid=1 and out_sum is held stable. On out_ready go to IDLE. out_sum keeps its value in IDLE until the next RESOLVE.
- start in any state other than IDLE is ignored, and err is not raised.
- Truncating C's MSB carry and the S+C carry-out is exact, because the true sum is at most MAX_OPS·(2^W−1), which is less than 2^ACC_W.

## Timing
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - S, C, remaining and out_sum go to 0.
  - in_ready, out_valid, busy and err go to 0.
  - Reset in any state abandons the operation with no output.
- in_ready is a registered state decode, so there is no combinational path from in_valid.
- out_valid does not depend combinationally on out_ready.
- Latency: the last operand is accepted at edge k. RESOLVE occupies cycle k→k+1, and out_valid is high from edge k+1.
- Throughput: with no stalls, N operands take N cycles. Start-to-start minimum is N+3 cycles (IDLE, N×ACCUM, RESOLVE, OUTPUT with out_ready=1).
- in_valid low in ACCUM stalls the operation with no state change.
- out_ready low in OUTPUT holds out_valid and out_sum indefinitely.
- err goes high for exactly the cycle after the illegal start edge.
- busy rises the edge after a legal start and falls the edge after the output handshake.

## Structure
- Package csa_pkg holds:
  - the state encoding constants (IDLE=2'd0, ACCUM=2'd1, RESOLVE=2'd2, OUTPUT=2'd3);
  - a function for ACC_W and CNT_W.
- Sub-module csa_3to2, parameterized by width: purely combinational, inputs x, y and z, outputs s=x^y^z and c=maj(x,y,z)<<1.
- The controller instantiates csa_3to2 once at ACC_W and owns the FSM, the counter, the S/C registers and the final adder.

## Test plan
- op_count=3, operands 13, 9, 4 back-to-back, out_ready=1 → out_sum=26, out_valid one cycle after RESOLVE, busy low after the handshake.
- op_count=3, operands 15, 11, 6 with one idle in_valid cycle between each → out_sum=32; no operand is lost or double-counted.
- op_count=8, all operands 15 → out_sum=120 (no overflow). Then op_count=1, operand 7 → out_sum=7, proving S/C are cleared between runs.
- op_count=0, and separately op_count=9 → err pulses once, in_ready stays 0, busy stays 0, state stays IDLE.
- In OUTPUT with out_sum=26, hold out_ready=0 for 3 cycles while toggling start → out_valid and out_sum stay stable, and start is ignored.
- Reset mid-run: rst_n=0 after 2 of 4 operands are accepted → all outputs are 0 on the next edge. A following run with op_count=2 and operands 13, 13 gives out_sum=26.
